cpu_run_ctrl: RTL and testbench

Input-side counterpart of the 7-segment display path: conditions the board's raw slide switches and step button into clean, synchronous control for the MIPS core and the display. Synchronises and debounces all inputs and runs a run/pause/single-step FSM. The FSM issues a one-cycle CPU clock-enable (cpu_en) instead of gating the 100 MHz clock. Also supplies a debounced debug address/mode and an executed-cycle counter.

---
 rtl/cpu_run_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: turns the board's raw pause switch, step button and debug
// switches into clean single-clock control for the MIPS core. All raw inputs
// are synchronised and debounced, then a run/pause/single-step FSM issues a
// one-cycle CPU advance strobe instead of gating the system clock.

// Debounce unit: holds a stable word and only adopts a new synced value once
// it has differed from the stable word for DB_CYCLES consecutive cycles.
module cpu_run_ctrl_debounce #(
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] stable_next
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] stable_q, stable_d;

    // Count consecutive mismatch cycles; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stable value and mismatch counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable      = stable_q;
    assign stable_next = stable_d;

endmodule

module cpu_run_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int RUN_DIV   = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sw_pause,
    input  logic        btn_step,
    input  logic [6:0]  sw_addr,
    input  logic [1:0]  sw_mode,
    output logic        cpu_en,
    output logic        paused,
    output logic [6:0]  addr_db,
    output logic [1:0]  mode_db,
    output logic [15:0] step_count
);

    localparam int DIVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_STEP
    } state_t;

    logic [10:0]     sync1_q, sync1_d;
    logic [10:0]     sync2_q, sync2_d;
    logic            pause_stable, pause_next;
    logic            step_stable, step_next_unused;
    logic [8:0]      bus_stable, bus_next_unused;
    logic            step_prev_q, step_prev_d;
    logic            step_req;
    state_t          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            cpu_en_q, cpu_en_d;
    logic            paused_q, paused_d;
    logic [15:0]     step_count_q, step_count_d;

    // Two-flop synchroniser on every raw bit: {pause, step, addr, mode}.
    always_comb begin
        sync1_d = {sw_pause, btn_step, sw_addr, sw_mode};
        sync2_d = sync1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    cpu_run_ctrl_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk         (clk),
        .reset       (reset),
        .synced      (sync2_q[10]),
        .stable      (pause_stable),
        .stable_next (pause_next)
    );

    cpu_run_ctrl_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk         (clk),
        .reset       (reset),
        .synced      (sync2_q[9]),
        .stable      (step_stable),
        .stable_next (step_next_unused)
    );

    cpu_run_ctrl_debounce #(.WIDTH(9), .DB_CYCLES(DB_CYCLES)) u_db_bus (
        .clk         (clk),
        .reset       (reset),
        .synced      (sync2_q[8:0]),
        .stable      (bus_stable),
        .stable_next (bus_next_unused)
    );

    // Rising edge of the debounced step level gives one request per press.
    always_comb begin
        step_prev_d = step_stable;
        step_req    = step_stable & ~step_prev_q;
    end

    // Run/pause/step FSM. Pause reacts to the debounced level on the same edge
    // it settles, so a switch flip reaches 'paused' with the debounce latency.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pause_next) begin
                    state_d = ST_PAUSED;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    cpu_en_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_PAUSED: begin
                div_d = '0;
                if (!pause_next) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: begin
                div_d   = '0;
                state_d = ST_PAUSED;
            end
            default: begin
                div_d   = '0;
                state_d = ST_RUN;
            end
        endcase
        paused_d     = (state_d != ST_RUN);
        step_count_d = step_count_q + {15'd0, cpu_en_d};
    end

    // FSM, divider and registered output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            div_q        <= '0;
            cpu_en_q     <= 1'b0;
            paused_q     <= 1'b0;
            step_count_q <= '0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_en_q     <= cpu_en_d;
            paused_q     <= paused_d;
            step_count_q <= step_count_d;
            step_prev_q  <= step_prev_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign paused     = paused_q;
    assign addr_db    = bus_stable[8:2];
    assign mode_db    = bus_stable[1:0];
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl with DB_CYCLES=4, RUN_DIV=8.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so "k cycles later" means k rising edges after the input change.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_pause;
    logic        btn_step;
    logic [6:0]  sw_addr;
    logic [1:0]  sw_mode;
    logic        cpu_en;
    logic        paused;
    logic [6:0]  addr_db;
    logic [1:0]  mode_db;
    logic [15:0] step_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DB_CYCLES(4), .RUN_DIV(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_pause   (sw_pause),
        .btn_step   (btn_step),
        .sw_addr    (sw_addr),
        .sw_mode    (sw_mode),
        .cpu_en     (cpu_en),
        .paused     (paused),
        .addr_db    (addr_db),
        .mode_db    (mode_db),
        .step_count (step_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic s, input logic [6:0] a, input logic [1:0] m);
        sw_pause = p;
        btn_step = s;
        sw_addr  = a;
        sw_mode  = m;
    endtask

    task automatic runCycles(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (cpu_en === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    initial begin
        int pulses;
        int first;
        int total;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 7'h00, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        checkOutput("rst_paused", {31'd0, paused}, 32'd0);
        checkOutput("rst_addr", {25'd0, addr_db}, 32'h0);
        checkOutput("rst_mode", {30'd0, mode_db}, 32'h0);
        checkOutput("rst_count", {16'd0, step_count}, 32'd0);
        reset = 1'b0;

        // Free run: ticks on edges 8,16,24,32,40.
        runCycles(40, pulses, first);
        checkOutput("run_first_tick", first, 32'd8);
        checkOutput("run_pulses", pulses, 32'd5);
        checkOutput("run_count", {16'd0, step_count}, 32'd5);
        checkOutput("run_paused", {31'd0, paused}, 32'd0);

        // Debug bus debounce: visible exactly 6 cycles after the change.
        applyStimulus(1'b0, 1'b0, 7'h25, 2'b10);
        repeat (5) @(negedge clk);
        checkOutput("addr_early", {25'd0, addr_db}, 32'h0);
        @(negedge clk);
        checkOutput("addr_settled", {25'd0, addr_db}, 32'h25);
        checkOutput("mode_settled", {30'd0, mode_db}, 32'h2);
        applyStimulus(1'b0, 1'b0, 7'h00, 2'b10);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 7'h25, 2'b10);
        repeat (8) @(negedge clk);
        checkOutput("addr_glitch", {25'd0, addr_db}, 32'h25);
        checkOutput("count_at_57", {16'd0, step_count}, 32'd7);

        // Pause: paused rises 6 cycles after the switch, then no ticks.
        applyStimulus(1'b1, 1'b0, 7'h25, 2'b10);
        repeat (5) @(negedge clk);
        checkOutput("pause_early", {31'd0, paused}, 32'd0);
        @(negedge clk);
        checkOutput("pause_set", {31'd0, paused}, 32'd1);
        runCycles(10, pulses, first);
        checkOutput("pause_no_tick", pulses, 32'd0);
        checkOutput("pause_count", {16'd0, step_count}, 32'd7);

        // Held step button: one strobe, 7 cycles after the press.
        applyStimulus(1'b1, 1'b1, 7'h25, 2'b10);
        runCycles(20, pulses, first);
        checkOutput("step_pulses", pulses, 32'd1);
        checkOutput("step_latency", first, 32'd7);
        applyStimulus(1'b1, 1'b0, 7'h25, 2'b10);
        runCycles(10, pulses, first);
        checkOutput("step_release", pulses, 32'd0);
        checkOutput("step_count1", {16'd0, step_count}, 32'd8);

        // Three clean presses.
        total = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 7'h25, 2'b10);
            runCycles(10, pulses, first);
            total += pulses;
            applyStimulus(1'b1, 1'b0, 7'h25, 2'b10);
            runCycles(10, pulses, first);
            total += pulses;
        end
        checkOutput("three_steps", total, 32'd3);
        checkOutput("three_count", {16'd0, step_count}, 32'd11);

        // Bouncing button made of 1-cycle pulses.
        total = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 7'h25, 2'b10);
            @(negedge clk);
            if (cpu_en === 1'b1) total++;
            applyStimulus(1'b1, 1'b0, 7'h25, 2'b10);
            @(negedge clk);
            if (cpu_en === 1'b1) total++;
        end
        runCycles(10, pulses, first);
        total += pulses;
        checkOutput("bounce_steps", total, 32'd0);
        checkOutput("bounce_count", {16'd0, step_count}, 32'd11);

        // Release pause and press step together: RUN wins, tick 8 after resume.
        applyStimulus(1'b0, 1'b1, 7'h25, 2'b10);
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) checkOutput("resume_early", {31'd0, paused}, 32'd1);
            if (k == 6) checkOutput("resume_run", {31'd0, paused}, 32'd0);
            if (cpu_en === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        checkOutput("resume_first_tick", first, 32'd14);
        checkOutput("resume_pulses", pulses, 32'd1);
        checkOutput("resume_count", {16'd0, step_count}, 32'd12);
        applyStimulus(1'b0, 1'b0, 7'h25, 2'b10);

        // Counter wrap: preload near the top, ticks follow at +2 and +10.
        force dut.step_count_q = 16'hFFFE;
        #1;
        release dut.step_count_q;
        runCycles(2, pulses, first);
        checkOutput("wrap_ffff", {16'd0, step_count}, 32'hFFFF);
        runCycles(8, pulses, first);
        checkOutput("wrap_zero", {16'd0, step_count}, 32'd0);

        // Enter STEP, then reset during the step cycle.
        applyStimulus(1'b1, 1'b0, 7'h25, 2'b10);
        runCycles(10, pulses, first);
        checkOutput("pause2_set", {31'd0, paused}, 32'd1);
        applyStimulus(1'b1, 1'b1, 7'h25, 2'b10);
        repeat (7) @(negedge clk);
        checkOutput("in_step_en", {31'd0, cpu_en}, 32'd1);
        checkOutput("in_step_count", {16'd0, step_count}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst2_cpu_en", {31'd0, cpu_en}, 32'd0);
        checkOutput("rst2_paused", {31'd0, paused}, 32'd0);
        checkOutput("rst2_addr", {25'd0, addr_db}, 32'h0);
        checkOutput("rst2_mode", {30'd0, mode_db}, 32'h0);
        checkOutput("rst2_count", {16'd0, step_count}, 32'd0);
        applyStimulus(1'b0, 1'b0, 7'h00, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_en", {31'd0, cpu_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
